// File: rtl/m8b_32_pkg.sv
// Shared PHY definitions for the 8-to-32 byte packer and its 32-to-8 counterpart.
package m8b_32_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HOLD_LEN       = 4;

  // Encoding is shared with the serializer FSM; keep values fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01
  } state_e;

endpackage

// File: rtl/m8b_32_win_cnt.sv
// Reloadable down-counter: valid is high while the count is nonzero.
module m8b_32_win_cnt #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic valid
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload wins over decrement so a new word always gets a full window.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign valid = (cnt_q != '0);

endmodule

// File: rtl/m8b_32.sv
// Receive-side byte-to-word packer: assembles MSB-first 32-bit words from a byte stream,
// drops and flags partial words interrupted by a valid drop.
module m8b_32
  import m8b_32_pkg::*;
#(
  parameter int unsigned BYTE_W         = m8b_32_pkg::BYTE_W,
  parameter int unsigned BYTES_PER_WORD = m8b_32_pkg::BYTES_PER_WORD
) (
  input  logic                             clk_4f,
  input  logic                             reset,
  input  logic [BYTE_W-1:0]                data_in_8,
  input  logic                             valid_in_8,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] data_8_32,
  output logic                             valid_8_32,
  output logic                             err_8_32
);

  localparam int unsigned WORD_W  = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;
  localparam int unsigned CNT_W   = $clog2(BYTES_PER_WORD);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic               word_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    err_d     = 1'b0;
    word_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in_8) begin
          shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], data_in_8};
          cnt_d   = CNT_W'(1);
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (valid_in_8) begin
          if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
            // Earliest byte sits at the top of the shift register, giving MSB-first order.
            data_d    = {shift_q, data_in_8};
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], data_in_8};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          shift_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  m8b_32_win_cnt #(
    .LEN (HOLD_LEN)
  ) u_win_cnt (
    .clk   (clk_4f),
    .rst   (reset),
    .load  (word_done),
    .valid (valid_8_32)
  );

  assign data_8_32 = data_q;
  assign err_8_32  = err_q;

endmodule

// File: tb/tb_m8b_32.sv
// Scoreboard bench for m8b_32: queue-based reference model with directed and random byte streams.
module tb_m8b_32;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_in_8;
  logic        valid_in_8;
  logic [31:0] data_8_32;
  logic        valid_8_32;
  logic        err_8_32;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [31:0] word;
  } exp_t;

  // Reference model state
  logic [7:0]  partial[$];
  exp_t        exp_q[$];
  int          err_q[$];
  int          cyc = 0;
  int          last_done = -100;
  logic [31:0] last_word = '0;

  m8b_32 dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .data_in_8  (data_in_8),
    .valid_in_8 (valid_in_8),
    .data_8_32  (data_8_32),
    .valid_8_32 (valid_8_32),
    .err_8_32   (err_8_32)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: words are any 4 consecutively sampled valid bytes starting from an empty buffer.
  always @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      partial.delete();
      exp_q.delete();
      err_q.delete();
      last_done = -100;
      last_word = '0;
    end else begin
      cyc++;
      if (valid_in_8) begin
        partial.push_back(data_in_8);
        if (partial.size() == 4) begin
          last_word = {partial[0], partial[1], partial[2], partial[3]};
          exp_q.push_back('{cyc: cyc, word: last_word});
          last_done = cyc;
          partial.delete();
        end
      end else if (partial.size() != 0) begin
        err_q.push_back(cyc);
        partial.delete();
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the model's expectations.
  always @(negedge clk_4f) begin
    if (!reset) begin
      logic exp_err;
      logic exp_valid;
      exp_valid = (cyc - last_done >= 0) && (cyc - last_done < 4);
      check("valid", {31'b0, valid_8_32}, {31'b0, exp_valid});
      check("data_hold", data_8_32, last_word);
      exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      check("err", {31'b0, err_8_32}, {31'b0, exp_err});
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("word", data_8_32, e.word);
      end
    end
  end

  task automatic send(input logic v, input logic [7:0] d);
    @(negedge clk_4f);
    valid_in_8 = v;
    data_in_8  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 8'hFF);
  endtask

  initial begin
    reset      = 1'b1;
    valid_in_8 = 1'b0;
    data_in_8  = 8'h00;
    #12;
    check("reset_data", data_8_32, 32'h0);
    check("reset_valid", {31'b0, valid_8_32}, 32'h0);
    check("reset_err", {31'b0, err_8_32}, 32'h0);
    @(negedge clk_4f);
    reset = 1'b0;

    // Single word, window expiry with data retained
    send(1'b1, 8'hDE); send(1'b1, 8'hAD); send(1'b1, 8'hBE); send(1'b1, 8'hEF);
    idle(7);
    check("deadbeef_retained", data_8_32, 32'hDEADBEEF);

    // Continuous stream of three words
    for (int i = 0; i < 12; i++) send(1'b1, 8'(i));
    idle(6);

    // Partial word dropped, then a clean word
    send(1'b1, 8'h11); send(1'b1, 8'h22);
    idle(2);
    for (int i = 1; i <= 4; i++) send(1'b1, 8'hA0 + 8'(i));
    idle(3);

    // Idle gaps full of 8'hFF between words
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) send(1'b1, 8'(16 * w + i));
      idle(w + 1);
    end

    // Async reset after 3 bytes of a word, during a valid window
    for (int i = 0; i < 4; i++) send(1'b1, 8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) send(1'b1, 8'hD0 + 8'(i));
    #2 reset = 1'b1;
    #1;
    check("async_data", data_8_32, 32'h0);
    check("async_valid", {31'b0, valid_8_32}, 32'h0);
    check("async_err", {31'b0, err_8_32}, 32'h0);
    valid_in_8 = 1'b0;
    @(negedge clk_4f);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 8'hE0 + 8'(i));
    idle(5);

    // Random stream with occasional valid drops
    for (int i = 0; i < 600; i++) begin
      send(($urandom_range(0, 7) != 0), 8'($urandom));
    end
    idle(8);

    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("err_queue_drained", err_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
